// File: rtl/misao_mem_responder_if.sv
// Core-side nibble memory bus between the MISA-O core (master) and its memory responder (slave).
interface misao_mem_responder_if;
    logic [15:0] mem_addr;
    logic        mem_rw;
    logic [3:0]  mem_data_out;
    logic [3:0]  mem_data_in;
    logic        mem_enable_read;
    logic        mem_enable_write;

    modport master (
        output mem_addr, mem_rw, mem_data_out,
        input  mem_data_in, mem_enable_read, mem_enable_write
    );

    modport slave (
        input  mem_addr, mem_rw, mem_data_out,
        output mem_data_in, mem_enable_read, mem_enable_write
    );
endinterface

// File: rtl/misao_mem_responder.sv
// Nibble memory responder for the MISA-O core: one on-chip array, waited reads, zero-latency writes.
// Define MISAO_MEM_LOADER_EN to add the host preload port (ld_valid/ld_addr/ld_data/ld_ready).
module misao_mem_responder #(
    parameter int DEPTH_LOG2  = 10,
    parameter int WAIT_STATES = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    misao_mem_responder_if.slave  bus
`ifdef MISAO_MEM_LOADER_EN
    ,
    input  logic                  ld_valid,
    input  logic [DEPTH_LOG2-1:0] ld_addr,
    input  logic [3:0]            ld_data,
    output logic                  ld_ready
`endif
);
    typedef enum logic [1:0] {IDLE, RD_WAIT, RD_VALID} state_t;

    localparam int         DEPTH     = 1 << DEPTH_LOG2;
    localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES);

    state_t                state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [DEPTH_LOG2-1:0] req_addr_q, req_addr_d;
    logic [3:0]            last_q, last_d;
    logic [3:0]            rd_data_q;
    logic [3:0]            mem_array [DEPTH];

    logic [DEPTH_LOG2-1:0] core_addr;
    logic                  addr_match;
    logic                  core_wr;
    logic                  ld_wr;
    logic                  rd_start;
    logic                  rd_pulse;
    logic                  ld_req;
    logic [DEPTH_LOG2-1:0] ld_addr_int;
    logic [3:0]            ld_data_int;
    logic                  we;
    logic [DEPTH_LOG2-1:0] waddr;
    logic [3:0]            wdata;

    // Upper address bits alias onto the array.
    assign core_addr  = bus.mem_addr[DEPTH_LOG2-1:0];
    assign addr_match = (core_addr == req_addr_q);

    if (DEPTH_LOG2 < 16) begin : g_alias
        logic unused_addr_hi;
        assign unused_addr_hi = ^bus.mem_addr[15:DEPTH_LOG2];
    end

`ifdef MISAO_MEM_LOADER_EN
    assign ld_req      = ld_valid;
    assign ld_addr_int = ld_addr;
    assign ld_data_int = ld_data;
    assign ld_ready    = ld_wr;
`else
    assign ld_req      = 1'b0;
    assign ld_addr_int = '0;
    assign ld_data_int = '0;
`endif

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        req_addr_d = req_addr_q;
        last_d     = last_q;
        core_wr    = 1'b0;
        ld_wr      = 1'b0;
        rd_start   = 1'b0;
        rd_pulse   = 1'b0;

        case (state_q)
            IDLE: begin
                // Core write first, then loader, and only then a new read.
                if (!bus.mem_rw) begin
                    core_wr = 1'b1;
                end else if (ld_req) begin
                    ld_wr = 1'b1;
                end else begin
                    rd_start   = 1'b1;
                    req_addr_d = core_addr;
                    cnt_d      = WAIT_INIT;
                    state_d    = (WAIT_STATES > 0) ? RD_WAIT : RD_VALID;
                end
            end
            RD_WAIT: begin
                if (!bus.mem_rw || !addr_match) begin
                    state_d = IDLE;
                end else if (cnt_q <= 4'd1) begin
                    cnt_d   = 4'd0;
                    state_d = RD_VALID;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RD_VALID: begin
                state_d = IDLE;
                if (bus.mem_rw && addr_match) begin
                    rd_pulse = 1'b1;
                    last_d   = rd_data_q;
                end
            end
            default: state_d = IDLE;
        endcase

        // Reset blocks every grant and pulse in the cycle it is asserted.
        if (rst) begin
            core_wr  = 1'b0;
            ld_wr    = 1'b0;
            rd_pulse = 1'b0;
        end
    end

    assign we    = core_wr | ld_wr;
    assign waddr = core_wr ? core_addr : ld_addr_int;
    assign wdata = core_wr ? bus.mem_data_out : ld_data_int;

    assign bus.mem_enable_read  = rd_pulse;
    assign bus.mem_enable_write = core_wr;
    assign bus.mem_data_in      = rd_pulse ? rd_data_q : last_q;

    // Array keeps its contents across reset; read data is registered at read start.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_array[waddr] <= wdata;
        end
        if (rd_start) begin
            rd_data_q <= mem_array[core_addr];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            req_addr_q <= '0;
            last_q     <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            req_addr_q <= req_addr_d;
            last_q     <= last_d;
        end
    end
endmodule
